// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the 8-bit program counter of the single-cycle CPU and
// drives the instruction-memory fetch handshake (IDLE/FETCH/EXEC/HALTED).
// Optional feature macro: PC_SEQ_LINK_EN adds a call input and a link
// register that captures the return address on call-type branches.
module pc_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            fetch_valid,
  input  logic            branch,
  input  logic [PC_W-1:0] branch_target,
  input  logic            stall,
  input  logic            halt,
`ifdef PC_SEQ_LINK_EN
  input  logic            call,
  output logic [PC_W-1:0] link_addr,
`endif
  output logic [PC_W-1:0] pc,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic            r_branch_pend;
  logic            w_branch_pend_nxt;
  logic [PC_W-1:0] r_pend_target;
  logic [PC_W-1:0] w_pend_target_nxt;
  logic            r_fetch_valid;
  logic            w_fetch_done;

`ifdef PC_SEQ_LINK_EN
  logic            r_pend_call;
  logic            w_pend_call_nxt;
  logic [PC_W-1:0] r_link;
  logic [PC_W-1:0] w_link_nxt;
`endif

  // Sequential increment wraps naturally at 2^PC_W.
  assign w_pc_inc     = r_pc + PC_W'(PC_STEP);
  assign w_fetch_done = (r_state == S_FETCH) && imem_ack;

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign fetch_valid = r_fetch_valid;
  assign pc          = r_pc;
  assign state       = r_state;
`ifdef PC_SEQ_LINK_EN
  assign link_addr   = r_link;
`endif

  // State, PC, pending-branch and fetch-valid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_branch_pend <= 1'b0;
      r_pend_target <= '0;
      r_fetch_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_branch_pend <= w_branch_pend_nxt;
      r_pend_target <= w_pend_target_nxt;
      // One pulse per accepted fetch, even if EXEC is then stalled.
      r_fetch_valid <= w_fetch_done;
    end
  end

`ifdef PC_SEQ_LINK_EN
  // Link register and the call bit that travels with a pending branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_call <= 1'b0;
      r_link      <= '0;
    end else begin
      r_pend_call <= w_pend_call_nxt;
      r_link      <= w_link_nxt;
    end
  end
`endif

  // Next-state and next-PC decision: halt > stall > branch > pend > step.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_branch_pend_nxt = r_branch_pend;
    w_pend_target_nxt = r_pend_target;
`ifdef PC_SEQ_LINK_EN
    w_pend_call_nxt   = r_pend_call;
    w_link_nxt        = r_link;
`endif
    case (r_state)
      S_IDLE: begin
        if (run) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // Branches resolved while the fetch is outstanding are deferred;
        // the most recent one overwrites any earlier pending target.
        if (branch) begin
          w_branch_pend_nxt = 1'b1;
          w_pend_target_nxt = branch_target;
`ifdef PC_SEQ_LINK_EN
          w_pend_call_nxt   = call;
`endif
        end
        if (imem_ack) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (halt) begin
          w_state_nxt = S_HALTED;
        end else if (stall) begin
          // A branch seen during a stall is kept so it is not lost if the
          // branch input drops before the stall releases.
          if (branch) begin
            w_branch_pend_nxt = 1'b1;
            w_pend_target_nxt = branch_target;
`ifdef PC_SEQ_LINK_EN
            w_pend_call_nxt   = call;
`endif
          end
        end else if (branch) begin
          w_pc_nxt          = branch_target;
          w_branch_pend_nxt = 1'b0;
          w_state_nxt       = S_FETCH;
`ifdef PC_SEQ_LINK_EN
          if (call) w_link_nxt = w_pc_inc;
`endif
        end else if (r_branch_pend) begin
          w_pc_nxt          = r_pend_target;
          w_branch_pend_nxt = 1'b0;
          w_state_nxt       = S_FETCH;
`ifdef PC_SEQ_LINK_EN
          if (r_pend_call) w_link_nxt = w_pc_inc;
`endif
        end else begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_FETCH;
        end
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer; optional link checks are built when
// PC_SEQ_LINK_EN is defined.
module tb_pc_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic       fetch_valid;
  logic       branch;
  logic [7:0] branch_target;
  logic       stall;
  logic       halt;
  logic [7:0] pc;
  logic [1:0] state;
`ifdef PC_SEQ_LINK_EN
  logic       call;
  logic [7:0] link_addr;
`endif

  int n_chk;
  int n_fail;

  pc_sequencer #(.PC_W(8), .RESET_PC(8'h00), .PC_STEP(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .fetch_valid   (fetch_valid),
    .branch        (branch),
    .branch_target (branch_target),
    .stall         (stall),
    .halt          (halt),
`ifdef PC_SEQ_LINK_EN
    .call          (call),
    .link_addr     (link_addr),
`endif
    .pc            (pc),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_chk++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h want 00", pc); end
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_chk++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", imem_addr); end
    n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b want 0", fetch_valid); end
`ifdef PC_SEQ_LINK_EN
    n_chk++; if (link_addr !== 8'h00) begin n_fail++; $display("FAIL reset_link got %h want 00", link_addr); end
`endif
  endtask

  task automatic test_sequential();
    int pulses;
    pulses = 0;
    run = 1'b1;
    step();
    run = 1'b0;
    n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL seq_run_state got %0d want 1", state); end
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_run_req got %b want 1", imem_req); end
    // One cycle with no ack: request must be held.
    step();
    n_chk++; if (imem_req !== 1'b1 || state !== 2'd1) begin n_fail++; $display("FAIL seq_hold_req got req=%b state=%0d want req=1 state=1", imem_req, state); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (imem_addr !== 8'(i)) begin n_fail++; $display("FAIL seq_addr got %h want %h", imem_addr, 8'(i)); end
      n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL seq_fv_in_fetch got %b want 0", fetch_valid); end
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      if (fetch_valid === 1'b1) pulses++;
      n_chk++; if (state !== 2'd2 || imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_exec got state=%0d req=%b want state=2 req=0", state, imem_req); end
      step();
    end
    n_chk++; if (pulses != 4) begin n_fail++; $display("FAIL seq_fv_pulses got %0d want 4", pulses); end
    n_chk++; if (imem_addr !== 8'h04 || imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_next got addr=%h req=%b want 04/1", imem_addr, imem_req); end
  endtask

  task automatic test_wrap();
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    branch = 1'b1; branch_target = 8'hFE;
    step();
    branch = 1'b0;
    n_chk++; if (imem_addr !== 8'hFE) begin n_fail++; $display("FAIL wrap_fe got %h want fe", imem_addr); end
    imem_ack = 1'b1; step(); imem_ack = 1'b0; step();
    n_chk++; if (imem_addr !== 8'hFF || imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_ff got addr=%h req=%b want ff/1", imem_addr, imem_req); end
    imem_ack = 1'b1; step(); imem_ack = 1'b0; step();
    n_chk++; if (imem_addr !== 8'h00 || imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_00 got addr=%h req=%b want 00/1", imem_addr, imem_req); end
  endtask

  task automatic test_branch();
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    branch = 1'b1; branch_target = 8'h40;
    step();
    branch = 1'b0;
    n_chk++; if (imem_addr !== 8'h40) begin n_fail++; $display("FAIL br_exec got %h want 40", imem_addr); end
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    branch = 1'b1; branch_target = 8'h05;
    step();
    branch = 1'b0;
    n_chk++; if (imem_addr !== 8'h05) begin n_fail++; $display("FAIL br_to05 got %h want 05", imem_addr); end
    // Branch arrives while fetch at 05 is outstanding.
    branch = 1'b1; branch_target = 8'h20;
    step();
    branch = 1'b0;
    n_chk++; if (pc !== 8'h05 || state !== 2'd1) begin n_fail++; $display("FAIL br_fetch_hold got pc=%h state=%0d want 05/1", pc, state); end
    imem_ack = 1'b1; step(); imem_ack = 1'b0; step();
    n_chk++; if (imem_addr !== 8'h20) begin n_fail++; $display("FAIL br_pend got %h want 20", imem_addr); end
    // Two branches in one fetch: the later one wins.
    branch = 1'b1; branch_target = 8'h30; step();
    branch_target = 8'h50; step();
    branch = 1'b0;
    imem_ack = 1'b1; step(); imem_ack = 1'b0; step();
    n_chk++; if (imem_addr !== 8'h50) begin n_fail++; $display("FAIL br_latest got %h want 50", imem_addr); end
  endtask

  task automatic test_stall_halt();
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    stall = 1'b1; branch = 1'b1; branch_target = 8'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (state !== 2'd2 || pc !== 8'h50) begin n_fail++; $display("FAIL stall_hold got state=%0d pc=%h want 2/50", state, pc); end
    end
    n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL stall_fv got %b want 0", fetch_valid); end
    stall = 1'b0; branch = 1'b0;
    step();
    n_chk++; if (imem_addr !== 8'h10 || imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_release got addr=%h req=%b want 10/1", imem_addr, imem_req); end
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    halt = 1'b1; branch = 1'b1; branch_target = 8'h77;
    step();
    halt = 1'b0; branch = 1'b0;
    n_chk++; if (state !== 2'd3 || pc !== 8'h10 || imem_req !== 1'b0) begin n_fail++; $display("FAIL halt got state=%0d pc=%h req=%b want 3/10/0", state, pc, imem_req); end
    run = 1'b1; imem_ack = 1'b1; branch = 1'b1; branch_target = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (state !== 2'd3 || pc !== 8'h10 || imem_req !== 1'b0) begin n_fail++; $display("FAIL halted_frozen got state=%0d pc=%h req=%b want 3/10/0", state, pc, imem_req); end
    end
    run = 1'b0; imem_ack = 1'b0; branch = 1'b0;
  endtask

  task automatic test_reset_midfetch();
    reset = 1'b1; step(); reset = 1'b0;
    run = 1'b1; step(); run = 1'b0;
    branch = 1'b1; branch_target = 8'h99; step(); branch = 1'b0;
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got req=%b want 1", imem_req); end
    run = 1'b1;
    reset = 1'b1; step(); reset = 1'b0;
    n_chk++; if (state !== 2'd0 || pc !== 8'h00 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid got state=%0d pc=%h req=%b want 0/00/0", state, pc, imem_req); end
    step(); run = 1'b0;
    n_chk++; if (imem_addr !== 8'h00 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_first got addr=%h req=%b want 00/1", imem_addr, imem_req); end
    imem_ack = 1'b1; step(); imem_ack = 1'b0; step();
    n_chk++; if (imem_addr !== 8'h01) begin n_fail++; $display("FAIL rst_mid_stale got %h want 01", imem_addr); end
  endtask

`ifdef PC_SEQ_LINK_EN
  task automatic test_link();
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    branch = 1'b1; branch_target = 8'h12; step(); branch = 1'b0;
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    branch = 1'b1; call = 1'b1; branch_target = 8'h80; step();
    branch = 1'b0; call = 1'b0;
    n_chk++; if (pc !== 8'h80 || link_addr !== 8'h13) begin n_fail++; $display("FAIL link_call got pc=%h link=%h want 80/13", pc, link_addr); end
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    branch = 1'b1; branch_target = 8'h90; step(); branch = 1'b0;
    n_chk++; if (pc !== 8'h90 || link_addr !== 8'h13) begin n_fail++; $display("FAIL link_plain got pc=%h link=%h want 90/13", pc, link_addr); end
    // Pending call branch links with the pc at apply time (90 -> 91).
    branch = 1'b1; call = 1'b1; branch_target = 8'hA0; step();
    branch = 1'b0; call = 1'b0;
    imem_ack = 1'b1; step(); imem_ack = 1'b0; step();
    n_chk++; if (pc !== 8'hA0 || link_addr !== 8'h91) begin n_fail++; $display("FAIL link_pend got pc=%h link=%h want a0/91", pc, link_addr); end
  endtask
`endif

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; branch = 1'b0;
    branch_target = 8'h00; stall = 1'b0; halt = 1'b0;
`ifdef PC_SEQ_LINK_EN
    call = 1'b0;
`endif
    test_reset();
    test_sequential();
    test_wrap();
    test_branch();
    test_stall_halt();
    test_reset_midfetch();
`ifdef PC_SEQ_LINK_EN
    test_link();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
